// File: rtl/alu_pkg.sv
// Shared definitions for the SimpleRISC execute stage.
// Op-select indices, divider states and a sign helper.
package alu_pkg;

    localparam int unsigned NUM_OPS = 13;

    localparam int unsigned ADD = 0;
    localparam int unsigned SUB = 1;
    localparam int unsigned CMP = 2;
    localparam int unsigned MUL = 3;
    localparam int unsigned DIV = 4;
    localparam int unsigned MOD = 5;
    localparam int unsigned LSL = 6;
    localparam int unsigned LSR = 7;
    localparam int unsigned ASR = 8;
    localparam int unsigned OR  = 9;
    localparam int unsigned AND = 10;
    localparam int unsigned NOT = 11;
    localparam int unsigned MOV = 12;

    localparam int unsigned DIV_ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Magnitude of a two's-complement word; -2^31 maps to 0x80000000.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative signed div/mod: unsigned restoring core with sign fix-up.
// One quotient bit per cycle; divide-by-zero skips straight to DONE.
module alu_divider
    import alu_pkg::*;
#(
    parameter int unsigned DIV_ITER = DIV_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_mod,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned CNT_W = $clog2(DIV_ITER + 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rem_q, rem_d;
    logic [31:0]       quo_q, quo_d;
    logic [31:0]       dvs_q, dvs_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              mod_q, mod_d;

    logic [32:0]       shifted;
    logic [31:0]       diff;
    logic              fits;
    logic [31:0]       quo_signed;
    logic [31:0]       rem_signed;

    // Next-state, datapath step and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mod_d    = mod_q;
        busy     = 1'b0;
        done     = 1'b0;

        // Remainder can never exceed the divisor, so a 32-bit diff suffices.
        shifted  = {rem_q, quo_q[31]};
        fits     = shifted >= {1'b0, dvs_q};
        diff     = shifted[31:0] - dvs_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy     = 1'b1;
                    dvs_d    = abs32(divisor);
                    sign_a_d = dividend[31];
                    sign_b_d = divisor[31];
                    mod_d    = is_mod;
                    cnt_d    = '0;
                    if (divisor == 32'd0) begin
                        quo_d   = 32'd0;
                        rem_d   = abs32(dividend);
                        state_d = DONE;
                    end else begin
                        quo_d   = abs32(dividend);
                        rem_d   = 32'd0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                busy  = 1'b1;
                quo_d = {quo_q[30:0], fits};
                rem_d = fits ? diff : shifted[31:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sign correction: quotient truncates toward zero, remainder follows A.
    always_comb begin
        quo_signed = (sign_a_q ^ sign_b_q) ? (~quo_q + 32'd1) : quo_q;
        rem_signed = sign_a_q ? (~rem_q + 32'd1) : rem_q;
        result     = mod_q ? rem_signed : quo_signed;
    end

    // Divider state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mod_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mod_q    <= mod_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// SimpleRISC execute stage: ALU mux, E/GT flags and branch resolution.
// Div/mod runs in alu_divider and freezes upstream via stall_ALU.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned DIV_ITER = DIV_ITER_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         A_ALU,
    input  logic [31:0]         B_ALU,
    input  logic [31:0]         pc_ALU,
    input  logic [31:0]         immx_ALU,
    input  logic [NUM_OPS-1:0]  aluSignals_ALU,
    input  logic                isBeq_ALU,
    input  logic                isBgt_ALU,
    input  logic                isUBranch_ALU,
    output logic [31:0]         aluResult,
    output logic                isBranchTaken,
    output logic [31:0]         branchPC,
    output logic                stall_ALU,
    output logic                flagE,
    output logic                flagGT
);

    logic        flag_e_q, flag_e_d;
    logic        flag_gt_q, flag_gt_d;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    assign div_start = aluSignals_ALU[DIV] | aluSignals_ALU[MOD];

    alu_divider #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .is_mod   (aluSignals_ALU[MOD]),
        .dividend (A_ALU),
        .divisor  (B_ALU),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );

    // One-hot result select; NOP bubbles and cmp yield zero.
    always_comb begin
        aluResult = 32'd0;
        unique case (1'b1)
            aluSignals_ALU[ADD]: aluResult = A_ALU + B_ALU;
            aluSignals_ALU[SUB]: aluResult = A_ALU - B_ALU;
            aluSignals_ALU[CMP]: aluResult = 32'd0;
            aluSignals_ALU[MUL]: aluResult = A_ALU * B_ALU;
            aluSignals_ALU[DIV],
            aluSignals_ALU[MOD]: aluResult = div_done ? div_result : 32'd0;
            aluSignals_ALU[LSL]: aluResult = A_ALU << B_ALU[4:0];
            aluSignals_ALU[LSR]: aluResult = A_ALU >> B_ALU[4:0];
            aluSignals_ALU[ASR]: aluResult = 32'($signed(A_ALU) >>> B_ALU[4:0]);
            aluSignals_ALU[OR]:  aluResult = A_ALU | B_ALU;
            aluSignals_ALU[AND]: aluResult = A_ALU & B_ALU;
            aluSignals_ALU[NOT]: aluResult = ~B_ALU;
            aluSignals_ALU[MOV]: aluResult = B_ALU;
            default:             aluResult = 32'd0;
        endcase
    end

    // Flags change only on a cmp; stalls and flushes leave them alone.
    always_comb begin
        flag_e_d  = flag_e_q;
        flag_gt_d = flag_gt_q;
        if (aluSignals_ALU[CMP]) begin
            flag_e_d  = (A_ALU == B_ALU);
            flag_gt_d = ($signed(A_ALU) > $signed(B_ALU));
        end
    end

    // Architectural flags register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_e_q  <= 1'b0;
            flag_gt_q <= 1'b0;
        end else begin
            flag_e_q  <= flag_e_d;
            flag_gt_q <= flag_gt_d;
        end
    end

    // Branch resolution against the registered flags.
    always_comb begin
        branchPC      = pc_ALU + immx_ALU;
        isBranchTaken = isUBranch_ALU
                      | (isBeq_ALU & flag_e_q)
                      | (isBgt_ALU & flag_gt_q);
    end

    assign stall_ALU = div_busy;
    assign flagE     = flag_e_q;
    assign flagGT    = flag_gt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vectors, an abstract reference
// model checked every cycle, plus pinned literal expectations.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A_ALU, B_ALU, pc_ALU, immx_ALU;
    logic [12:0] aluSignals_ALU;
    logic        isBeq_ALU, isBgt_ALU, isUBranch_ALU;
    logic [31:0] aluResult, branchPC;
    logic        isBranchTaken, stall_ALU, flagE, flagGT;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk            (clk),
        .reset          (reset),
        .A_ALU          (A_ALU),
        .B_ALU          (B_ALU),
        .pc_ALU         (pc_ALU),
        .immx_ALU       (immx_ALU),
        .aluSignals_ALU (aluSignals_ALU),
        .isBeq_ALU      (isBeq_ALU),
        .isBgt_ALU      (isBgt_ALU),
        .isUBranch_ALU  (isUBranch_ALU),
        .aluResult      (aluResult),
        .isBranchTaken  (isBranchTaken),
        .branchPC       (branchPC),
        .stall_ALU      (stall_ALU),
        .flagE          (flagE),
        .flagGT         (flagGT)
    );

    int checks = 0;
    int errors = 0;

    // Current instruction as the bench sees it (-1 = NOP bubble).
    int cur_op = -1;

    // Reference model state.
    logic m_e  = 1'b0;
    logic m_gt = 1'b0;
    int   m_cyc = 0;

    // Pinned literal expectations consumed at the next sample point.
    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } pin_t;
    pin_t pins[$];
    int   stall_run = 0;

    function automatic logic [31:0] model_res(input int op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        longint             p;
        logic [4:0]         sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        p  = longint'(sa) * longint'(sb);
        case (op)
            ADD: return a + b;
            SUB: return a - b;
            CMP: return 32'd0;
            MUL: return p[31:0];
            DIV: begin
                if (b == 32'd0) return 32'd0;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            MOD: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            LSL: return a << sh;
            LSR: return a >> sh;
            ASR: return sa >>> sh;
            OR:  return a | b;
            AND: return a & b;
            NOT: return ~b;
            MOV: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int cycles_stalled(input logic [31:0] b);
        return (b == 32'd0) ? 1 : 33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model update: flags on cmp, div/mod residency counter.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e   = 1'b0;
            m_gt  = 1'b0;
            m_cyc = 0;
        end else begin
            if (cur_op == int'(CMP)) begin
                m_e  = (A_ALU == B_ALU);
                m_gt = ($signed(A_ALU) > $signed(B_ALU));
            end
            if (cur_op == int'(DIV) || cur_op == int'(MOD)) begin
                if (m_cyc >= cycles_stalled(B_ALU)) m_cyc = 0;
                else m_cyc = m_cyc + 1;
            end else begin
                m_cyc = 0;
            end
        end
    end

    logic        c_div;
    logic        c_stall;
    logic        c_take;
    pin_t        c_p;
    logic [31:0] c_act;

    // Single compare process: model check every cycle, then pinned literals.
    always @(negedge clk) begin
        c_div   = (cur_op == int'(DIV) || cur_op == int'(MOD));
        c_stall = c_div && (m_cyc < cycles_stalled(B_ALU));
        c_take  = isUBranch_ALU | (isBeq_ALU & m_e) | (isBgt_ALU & m_gt);
        if (stall_ALU) stall_run++;
        chk("stall", {31'd0, stall_ALU}, {31'd0, c_stall});
        if (!c_stall) chk("result", aluResult, model_res(cur_op, A_ALU, B_ALU));
        chk("flagE", {31'd0, flagE}, {31'd0, m_e});
        chk("flagGT", {31'd0, flagGT}, {31'd0, m_gt});
        chk("taken", {31'd0, isBranchTaken}, {31'd0, c_take});
        chk("branchPC", branchPC, pc_ALU + immx_ALU);
        while (pins.size() > 0) begin
            c_p = pins.pop_front();
            case (c_p.sel)
                0:       c_act = aluResult;
                1:       c_act = {31'd0, stall_ALU};
                2:       c_act = {31'd0, isBranchTaken};
                3:       c_act = branchPC;
                4:       c_act = {31'd0, flagE};
                5:       c_act = {31'd0, flagGT};
                default: c_act = stall_run;
            endcase
            chk(c_p.name, c_act, c_p.exp);
        end
        if (!stall_ALU) stall_run = 0;
    end

    task automatic pin(input int sel, input logic [31:0] exp, input string name);
        pin_t p;
        p.sel  = sel;
        p.exp  = exp;
        p.name = name;
        pins.push_back(p);
    endtask

    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic beq, input logic bgt, input logic ub);
        logic [12:0] s;
        s = '0;
        if (op >= 0) s[op] = 1'b1;
        cur_op         = op;
        aluSignals_ALU = s;
        A_ALU          = a;
        B_ALU          = b;
        pc_ALU         = pc;
        immx_ALU       = imm;
        isBeq_ALU      = beq;
        isBgt_ALU      = bgt;
        isUBranch_ALU  = ub;
    endtask

    // Present an instruction for ncyc cycles; returns inside the last cycle.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic beq, input logic bgt, input logic ub,
                         input int ncyc);
        @(posedge clk);
        #1;
        drive(op, a, b, pc, imm, beq, bgt, ub);
        repeat (ncyc - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          t_op[11] = '{SUB, MUL, LSL, LSR, ASR, OR, AND, NOT, MOV, -1, CMP};
    logic [31:0] t_a[11]  = '{32'd3, 32'hFFFF_FFFD, 32'd1, 32'h8000_0000,
                              32'h8000_0000, 32'hF0, 32'hF0, 32'h1234_5678,
                              32'hDEAD, 32'd5, 32'd1};
    logic [31:0] t_b[11]  = '{32'd5, 32'd5, 32'h23, 32'd4, 32'd4, 32'h0F,
                              32'h3C, 32'd0, 32'h1234, 32'd6, 32'd2};
    logic [31:0] t_e[11]  = '{32'hFFFF_FFFE, 32'hFFFF_FFF1, 32'd8, 32'h0800_0000,
                              32'hF800_0000, 32'hFF, 32'h30, 32'hFFFF_FFFF,
                              32'h1234, 32'd0, 32'd0};

    initial begin
        reset = 1'b1;
        drive(-1, 0, 0, 0, 0, 0, 0, 0);
        pin(0, 0, "rst_result");
        pin(2, 0, "rst_taken");
        pin(3, 0, "rst_branchPC");
        pin(1, 0, "rst_stall");
        pin(4, 0, "rst_flagE");
        pin(5, 0, "rst_flagGT");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 1);
        pin(0, 32'h8000_0000, "add_wrap");
        pin(1, 0, "add_stall");

        issue(CMP, 32'd5, 32'd5, 0, 0, 0, 0, 0, 1);
        issue(-1, 0, 0, 32'h100, 32'h20, 1, 0, 0, 1);
        pin(4, 1, "cmp55_flagE");
        pin(5, 0, "cmp55_flagGT");
        pin(2, 1, "beq_taken");
        pin(3, 32'h120, "beq_target");

        issue(CMP, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 1);
        issue(-1, 0, 0, 32'h200, 32'h8, 0, 1, 0, 1);
        pin(5, 0, "cmpneg_flagGT");
        pin(2, 0, "bgt_not_taken");
        issue(-1, 0, 0, 32'h40, 32'hFFFF_FFF0, 0, 0, 1, 1);
        pin(2, 1, "b_taken");
        pin(3, 32'h30, "b_target");

        for (int i = 0; i < 11; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 0, 0, 0, 0, 0, 1);
            pin(0, t_e[i], $sformatf("op%0d_vec%0d", t_op[i], i));
        end

        issue(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 34);
        pin(0, 32'hFFFF_FFFD, "div_m7_2");
        pin(6, 33, "div_m7_2_stalls");
        issue(MOD, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 34);
        pin(0, 32'hFFFF_FFFF, "mod_m7_2");

        issue(DIV, 32'd9, 32'd0, 0, 0, 0, 0, 0, 2);
        pin(0, 32'd0, "div_by_zero");
        pin(6, 1, "div0_stalls");
        issue(MOD, 32'd9, 32'd0, 0, 0, 0, 0, 0, 2);
        pin(0, 32'd9, "mod_by_zero");

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 34);
        pin(0, 32'h8000_0000, "div_ovf");
        issue(MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 34);
        pin(0, 32'd0, "mod_ovf");

        issue(CMP, 32'd7, 32'd3, 0, 0, 0, 0, 0, 1);
        issue(DIV, 32'd100, 32'd7, 0, 0, 0, 0, 0, 11);
        pin(5, 1, "pre_rst_flagGT");
        pin(1, 1, "pre_rst_stall");
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(-1, 0, 0, 0, 0, 0, 0, 0);
        pin(1, 0, "midrst_stall");
        pin(5, 0, "midrst_flagGT");
        pin(4, 0, "midrst_flagE");
        @(posedge clk);
        #1 reset = 1'b0;

        issue(DIV, 32'd100, 32'd7, 0, 0, 0, 0, 0, 34);
        pin(0, 32'd14, "div_100_7");
        pin(6, 33, "div_100_7_stalls");
        issue(MOD, 32'd100, 32'd7, 0, 0, 0, 0, 0, 34);
        pin(0, 32'd2, "mod_100_7");

        issue(-1, 0, 0, 0, 0, 0, 0, 0, 2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
